// File: rtl/nibble_serial_byte_adder_if.sv
// Bundle of the operand handshake, nibble adder link and result handshake
// for nibble_serial_byte_adder.
interface nibble_serial_byte_adder_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       na_a;
  logic [7:0]       na_b;
  logic             na_ctrl;
  logic [4:0]       na_q;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       sum;
  logic             ovf;
  logic [CNT_W-1:0] op_count;

  // environment side: producer, nibble adder and consumer
  modport master (
    output in_valid, in_a, in_b, na_q, out_ready,
    input  in_ready, na_a, na_b, na_ctrl, out_valid, sum, ovf, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, na_q, out_ready,
    output in_ready, na_a, na_b, na_ctrl, out_valid, sum, ovf, op_count
  );
endinterface

// File: rtl/nibble_serial_byte_adder.sv
// Byte adder built from two passes through an external nibble adder:
// low nibble first, then high nibble plus the low-pass carry.
module nibble_serial_byte_adder #(
  parameter int CNT_W = 8
) (
  input logic                        clk,
  input logic                        rst,
  nibble_serial_byte_adder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state;
  logic [7:0]       na_a_q, na_b_q;
  logic [8:0]       sum_q;
  logic             carry, ovf_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       hi_sum;

  // 15+15+1 fits in 5 bits, so no extra headroom is needed
  assign hi_sum = bus.na_q + {4'b0, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      na_a_q      <= '0;
      na_b_q      <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          na_a_q <= bus.in_a;
          na_b_q <= bus.in_b;
          state  <= LO;
        end
        LO: begin
          sum_q[3:0] <= bus.na_q[3:0];
          carry      <= bus.na_q[4];
          state      <= HI;
        end
        HI: begin
          sum_q[8:4]  <= hi_sum;
          ovf_q       <= hi_sum[4];
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          cnt_q       <= cnt_q + CNT_W'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.na_ctrl   = (state == HI);
  assign bus.na_a      = na_a_q;
  assign bus.na_b      = na_b_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_nibble_serial_byte_adder.sv
// Self-checking bench: nibble adder model on the na_* link, scoreboard of
// expected byte sums pushed at acceptance and popped at hand-off.
module tb_nibble_serial_byte_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt = '0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  nibble_serial_byte_adder_if #(.CNT_W(8)) bif();

  nibble_serial_byte_adder #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // behavioural nibble adder
  assign bif.na_q = bif.na_ctrl ? ({1'b0, bif.na_a[7:4]} + {1'b0, bif.na_b[7:4]})
                                : ({1'b0, bif.na_a[3:0]} + {1'b0, bif.na_b[3:0]});

  // one full transaction; bp = cycles of out_ready=0 after out_valid,
  // churn = wiggle in_* during that back-pressure window
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int bp, input bit churn);
    int k;
    logic [8:0] exp_sum, held;
    k = 0;
    while (!bif.in_ready && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (!bif.in_ready) begin
      errors++; $display("FAIL in_ready_timeout got=%0b want=1", bif.in_ready);
      return;
    end
    bif.in_a = a; bif.in_b = b; bif.in_valid = 1'b1;
    sb.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    bif.in_valid = 1'b0;
    k = 0;
    while (!bif.out_valid && k < 20) begin
      if (k < 2) begin
        checks++;
        if (bif.na_ctrl !== (k == 1)) begin
          errors++; $display("FAIL na_ctrl pass=%0d got=%0b want=%0b", k, bif.na_ctrl, k == 1);
        end
      end
      @(negedge clk); k++;
    end
    checks++;
    if (k !== 2) begin
      errors++; $display("FAIL latency got=%0d want=2", k);
      if (!bif.out_valid) begin void'(sb.pop_front()); return; end
    end
    held = bif.sum;
    for (int i = 0; i < bp; i++) begin
      if (churn) begin
        bif.in_valid = i[0];
        bif.in_a = 8'($urandom); bif.in_b = 8'($urandom);
      end
      @(negedge clk);
      checks++;
      if (bif.sum !== held || bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0 ||
          bif.op_count !== exp_cnt || bif.na_a !== a || bif.na_b !== b) begin
        errors++;
        $display("FAIL backpressure cyc=%0d sum=%h/%h vld=%0b rdy=%0b cnt=%0d/%0d na_a=%h/%h na_b=%h/%h",
                 i, bif.sum, held, bif.out_valid, bif.in_ready, bif.op_count, exp_cnt,
                 bif.na_a, a, bif.na_b, b);
      end
    end
    bif.in_valid = 1'b0;
    exp_sum = sb.pop_front();
    checks++;
    if (bif.sum !== exp_sum || bif.ovf !== exp_sum[8]) begin
      errors++; $display("FAIL sum a=%h b=%h got=%h ovf=%0b want=%h ovf=%0b",
                         a, b, bif.sum, bif.ovf, exp_sum, exp_sum[8]);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (bif.op_count !== exp_cnt || bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL handoff cnt=%0d want=%0d vld=%0b rdy=%0b",
                         bif.op_count, exp_cnt, bif.out_valid, bif.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_cnt = '0;
    sb.delete();
    checks++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0 || bif.op_count !== 8'd0 ||
        bif.sum !== 9'd0 || bif.ovf !== 1'b0 || bif.na_a !== 8'd0 || bif.na_b !== 8'd0) begin
      errors++; $display("FAIL reset rdy=%0b vld=%0b cnt=%0d sum=%h ovf=%0b na_a=%h na_b=%h want 1,0,0,0,0,0,0",
                         bif.in_ready, bif.out_valid, bif.op_count, bif.sum, bif.ovf, bif.na_a, bif.na_b);
    end
  endtask

  task automatic test_basic();
    do_op(8'h3C, 8'h5A, 0, 1'b0);
    checks++;
    if (bif.sum !== 9'h096 || bif.op_count !== 8'd1) begin
      errors++; $display("FAIL basic sum=%h cnt=%0d want=096 cnt=1", bif.sum, bif.op_count);
    end
  endtask

  task automatic test_max();
    do_op(8'hFF, 8'hFF, 0, 1'b0);
    checks++;
    if (bif.ovf !== 1'b1 || bif.sum !== 9'h1FE) begin
      errors++; $display("FAIL max sum=%h ovf=%0b want=1fe ovf=1", bif.sum, bif.ovf);
    end
  endtask

  task automatic test_zero();
    do_op(8'h00, 8'h00, 0, 1'b0);
    do_op(8'h21, 8'h12, 1, 1'b0);
    checks++;
    if (bif.sum !== 9'h033 || bif.ovf !== 1'b0) begin
      errors++; $display("FAIL held_in_idle sum=%h ovf=%0b want=033 ovf=0", bif.sum, bif.ovf);
    end
  endtask

  task automatic test_backpressure();
    do_op(8'h77, 8'h99, 5, 1'b1);
    do_op(8'h80, 8'h80, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    while (!bif.in_ready) @(negedge clk);
    bif.in_a = 8'hAB; bif.in_b = 8'hCD; bif.in_valid = 1'b1;
    @(negedge clk);                 // LO
    bif.in_valid = 1'b0;
    @(negedge clk);                 // HI
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.op_count !== 8'd0 || bif.in_ready !== 1'b1 ||
        bif.na_a !== 8'd0 || bif.na_b !== 8'd0) begin
      errors++; $display("FAIL reset_mid vld=%0b cnt=%0d rdy=%0b na_a=%h na_b=%h want 0,0,1,0,0",
                         bif.out_valid, bif.op_count, bif.in_ready, bif.na_a, bif.na_b);
    end
    @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b0) begin
      errors++; $display("FAIL aborted_result vld=%0b want=0", bif.out_valid);
    end
    do_op(8'h10, 8'h20, 0, 1'b0);
    checks++;
    if (bif.sum !== 9'h030) begin
      errors++; $display("FAIL after_reset sum=%h want=030", bif.sum);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int n = 1; n <= 256; n++) begin
      do_op(8'h01, 8'h01, 0, 1'b0);
      if (n == 255) begin
        checks++;
        if (bif.op_count !== 8'd255) begin
          errors++; $display("FAIL count_255 got=%0d want=255", bif.op_count);
        end
      end
    end
    checks++;
    if (bif.op_count !== 8'd0) begin
      errors++; $display("FAIL count_wrap got=%0d want=0", bif.op_count);
    end
  endtask

  initial begin
    bif.in_valid = 1'b0; bif.in_a = '0; bif.in_b = '0; bif.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
